// File: rtl/alu_pkg.sv
// Shared types and constants for the logic-unit sequencing front-end.
//   logic_sel_e : operation select of the 32-bit logic unit
//   red_state_e : packet state of the reducer (IDLE / ACCUM)
//   ALU_WIDTH   : native operand width of the logic unit
//   logic_op    : behavioural view of the logic unit, for use beside the
//                 reducer where no gate-level unit is available
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [1:0] {
        LOGIC_AND = 2'b00,
        LOGIC_OR  = 2'b01,
        LOGIC_XOR = 2'b10,
        LOGIC_NOR = 2'b11
    } logic_sel_e;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } red_state_e;

    function automatic logic [ALU_WIDTH-1:0] logic_op(
        input logic [ALU_WIDTH-1:0] a,
        input logic [ALU_WIDTH-1:0] b,
        input logic_sel_e           sel
    );
        logic [ALU_WIDTH-1:0] r;
        r = '0;
        case (sel)
            LOGIC_AND: r = a & b;
            LOGIC_OR:  r = a | b;
            LOGIC_XOR: r = a ^ b;
            LOGIC_NOR: r = ~(a | b);
            default:   r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_logic_reducer_if.sv
// Bundle of all non-clock signals of alu_logic_reducer.
//   in_*   : operand beat stream (valid/ready, in_last closes a packet)
//   alu_*  : drive/capture of the combinational logic unit
//   out_*  : packet result stream (valid/ready)
// Modports:
//   slave  : the reducer itself
//   master : the environment (beat source, logic unit, result sink)
interface alu_logic_reducer_if
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CNT_W = 8
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic_sel_e       in_sel;
    logic             in_last;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic_sel_e       alu_sel;
    logic [WIDTH-1:0] alu_result;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [CNT_W-1:0] out_beats;
    logic             out_err;

    modport slave (
        input  in_valid, in_a, in_b, in_sel, in_last,
        output in_ready,
        output alu_a, alu_b, alu_sel,
        input  alu_result,
        output out_valid, out_result, out_beats, out_err,
        input  out_ready
    );

    modport master (
        output in_valid, in_a, in_b, in_sel, in_last,
        input  in_ready,
        input  alu_a, alu_b, alu_sel,
        output alu_result,
        input  out_valid, out_result, out_beats, out_err,
        output out_ready
    );

endinterface

// File: rtl/alu_logic_reducer.sv
// Sequencing front-end for the combinational 32-bit logic unit.
// Accepts operand beats grouped into packets, drives the logic unit with
// (a or accumulator, b, select), and folds every beat into one result per
// packet. A one-beat packet yields a registered a-op-b.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : alu_logic_reducer_if.slave (beat input, logic unit, result out)
// Parameters:
//   WIDTH : operand/result width, must match the logic unit
//   CNT_W : beat-counter width; counts saturate at 2**CNT_W-1
module alu_logic_reducer
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_logic_reducer_if.slave  bus
);

    red_state_e       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic_sel_e       sel_q, sel_d;
    logic             err_q, err_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_result_q, out_result_d;
    logic [CNT_W-1:0] out_beats_q, out_beats_d;
    logic             out_err_q, out_err_d;

    logic             in_ready;
    logic             accept;
    logic             cnt_full;

    // A new beat may enter while the previous result leaves this cycle.
    assign in_ready = !out_valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;
    assign cnt_full = &cnt_q;

    // Operand mux: the first beat uses in_a/in_sel, later beats chain the
    // accumulator under the select latched at packet start.
    assign bus.alu_a   = (state_q == IDLE) ? bus.in_a   : acc_q;
    assign bus.alu_sel = (state_q == IDLE) ? bus.in_sel : sel_q;
    assign bus.alu_b   = bus.in_b;

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_beats  = out_beats_q;
    assign bus.out_err    = out_err_q;

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        sel_d        = sel_q;
        err_d        = err_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_beats_d  = out_beats_q;
        out_err_d    = out_err_q;

        if (accept) begin
            acc_d = bus.alu_result;
            if (state_q == IDLE) begin
                sel_d   = bus.in_sel;
                cnt_d   = CNT_W'(1);
                err_d   = 1'b0;
                state_d = bus.in_last ? IDLE : ACCUM;
            end else begin
                // Saturate the count and flag overflow; a select change
                // mid-packet is flagged but sel_q keeps driving the unit.
                cnt_d = cnt_full ? cnt_q : cnt_q + CNT_W'(1);
                err_d = err_q || cnt_full || (bus.in_sel != sel_q);
                if (bus.in_last) begin
                    state_d = IDLE;
                end
            end
        end

        // Output register runs independently of the packet state: a closing
        // beat reloads it even while the previous result is being consumed.
        if (accept && bus.in_last) begin
            out_valid_d  = 1'b1;
            out_result_d = bus.alu_result;
            out_beats_d  = cnt_d;
            out_err_d    = err_d;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            sel_q        <= LOGIC_AND;
            err_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_beats_q  <= '0;
            out_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            err_q        <= err_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_beats_q  <= out_beats_d;
            out_err_q    <= out_err_d;
        end
    end

endmodule
